// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one data memory between instruction fetch (port 0)
// and load/store (port 1). One memory pulse per access; ack, err and rdata are registered.
module mem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 1024,
  parameter int MEM_LAT   = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_MemRead,
  output logic              o_MemWrite,
  input  logic              i_mem_valid,
  input  logic [DATA_W-1:0] i_mem_data
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ERR, S_DONE} state_e;

  localparam int                CNT_MAX  = (TIMEOUT > MEM_LAT) ? TIMEOUT : MEM_LAT;
  localparam int                CNT_W    = $clog2(CNT_MAX) + 1;
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              done;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    rdata_d      = rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    err_d        = 1'b0;
    done         = 1'b0;

    // Under contention the port that did not win last time goes first.
    sel       = (i_req0 && i_req1) ? ~last_grant_q : i_req1;
    sel_we    = sel ? i_we1 : i_we0;
    sel_addr  = sel ? i_addr1 : i_addr0;
    sel_wdata = sel ? i_wdata1 : i_wdata0;

    case (state_q)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          grant_d = sel;
          we_d    = sel_we;
          if ((sel_addr[2:0] == 3'b000) && (sel_addr <= MAX_ADDR)) begin
            state_d     = S_ISSUE;
            mem_addr_d  = sel_addr;
            mem_data_d  = sel_wdata;
            mem_read_d  = ~sel_we;
            mem_write_d = sel_we;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (we_q) begin
          if (cnt_q == CNT_W'(MEM_LAT - 1)) done = 1'b1;
        end else if (i_mem_valid) begin
          done    = 1'b1;
          rdata_d = i_mem_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done    = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
        if (done) state_d = S_DONE;
      end
      S_ERR: begin
        done    = 1'b1;
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = S_DONE;
      end
      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values, so ack lands in the DONE cycle.
    ack0_d = done & ~grant_q;
    ack1_d = done & grant_q;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  assign o_ack0     = ack0_q;
  assign o_ack1     = ack1_q;
  assign o_err      = err_q;
  assign o_busy     = busy_q;
  assign o_rdata    = rdata_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_MemRead  = mem_read_q;
  assign o_MemWrite = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, transaction-level reference model,
// directed scenarios followed by randomized two-port traffic.
module tb_mem_arbiter;

  localparam int MEM_BYTES = 1024;
  localparam int MEM_LAT   = 8;
  localparam int TIMEOUT   = 16;
  localparam int WORDS     = MEM_BYTES / 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [63:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err, busy, mem_read, mem_write;
  logic [63:0] rdata, mem_addr, mem_data;
  logic        mem_valid;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata(rdata), .o_err(err), .o_busy(busy),
    .o_mem_addr(mem_addr), .o_mem_data(mem_data),
    .o_MemRead(mem_read), .o_MemWrite(mem_write),
    .i_mem_valid(mem_valid), .i_mem_data(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Preloaded memory contents, shared knowledge of memory model and reference model.
  function automatic logic [63:0] init_word(input int idx);
    if (idx == 2) return 64'h1122334455667788;
    return 64'h0123456700000000 ^ (64'(idx) * 64'h9E3779B97F4A7C15);
  endfunction

  // ---------------- memory model (fixed read latency, optional withholding) ----------
  logic [63:0] mem_arr [WORDS];
  bit          mem_vld [WORDS];
  int          lat;
  logic [63:0] rd_word;
  bit          withhold = 1'b0;

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    int idx;
    idx = int'(a[9:3]);
    return mem_vld[idx] ? mem_arr[idx] : init_word(idx);
  endfunction

  always @(posedge clk) begin
    mem_valid <= (lat == 1);
    mem_rdata <= rd_word;
    if (mem_read && !withhold) begin
      lat     <= MEM_LAT - 1;
      rd_word <= mem_word(mem_addr);
    end else if (lat > 0) begin
      lat <= lat - 1;
    end
    if (mem_write) begin
      mem_arr[int'(mem_addr[9:3])] <= mem_data;
      mem_vld[int'(mem_addr[9:3])] <= 1'b1;
    end
  end

  // ---------------- cycle counter and bus monitor -------------------------------------
  int          cyc = 0;
  int          pulse_cnt = 0;
  int          last_pulse_cyc = 0;
  bit          last_pulse_we;
  logic [63:0] last_pulse_addr;
  int          ack_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      if (pulse_cnt > 0) check("pulse_gap_ge10", 64'((cyc - last_pulse_cyc) >= 10), 64'd1);
      check("pulse_exclusive", 64'(mem_read & mem_write), 64'd0);
      pulse_cnt       <= pulse_cnt + 1;
      last_pulse_cyc  <= cyc;
      last_pulse_we   <= mem_write;
      last_pulse_addr <= mem_addr;
    end
    if (ack0 || ack1) ack_cnt <= ack_cnt + 1;
  end

  // ---------------- transaction-level reference model ---------------------------------
  logic [63:0] ref_arr [WORDS];
  bit          ref_vld [WORDS];
  bit          m_last = 1'b1;
  int          n_txn = 0;
  bit          obs_port;

  function automatic logic [63:0] ref_word(input logic [63:0] a);
    int idx;
    idx = int'(a / 8);
    return ref_vld[idx] ? ref_arr[idx] : init_word(idx);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called 1ns after the edge that starts the IDLE cycle in which the request is seen.
  task automatic expect_txn(input string tag);
    bit          port, we, legal, got, exp_err;
    logic [63:0] a, wd, exp_rdata;
    int          t0, p0, exp_lat;
    port  = (req0 && req1) ? !m_last : req1;
    we    = port ? we1 : we0;
    a     = port ? addr1 : addr0;
    wd    = port ? wdata1 : wdata0;
    legal = (a % 8 == 0) && (a <= 64'(MEM_BYTES - 8));
    exp_rdata = '0;
    exp_err   = 1'b0;
    if (!legal) begin
      exp_lat = 2;
      exp_err = 1'b1;
    end else if (we) begin
      exp_lat = MEM_LAT + 2;
    end else if (withhold) begin
      exp_lat = TIMEOUT + 2;
      exp_err = 1'b1;
    end else begin
      exp_lat   = MEM_LAT + 2;
      exp_rdata = ref_word(a);
    end
    t0  = cyc;
    p0  = pulse_cnt;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, ":ack_seen"}, 64'(got), 64'd1);
    if (got) begin
      obs_port = ack1;
      check({tag, ":latency"}, 64'(cyc - t0), 64'(exp_lat));
      check({tag, ":ack_port"}, {62'd0, ack1, ack0}, port ? 64'd2 : 64'd1);
      check({tag, ":err"}, 64'(err), 64'(exp_err));
      check({tag, ":busy"}, 64'(busy), 64'd1);
      if (!we || !legal) check({tag, ":rdata"}, rdata, exp_rdata);
      check({tag, ":pulses"}, 64'(pulse_cnt - p0), legal ? 64'd1 : 64'd0);
      if (legal) begin
        check({tag, ":pulse_cycle"}, 64'(last_pulse_cyc), 64'(t0 + 1));
        check({tag, ":pulse_kind"}, 64'(last_pulse_we), 64'(we));
        check({tag, ":pulse_addr"}, last_pulse_addr, a);
      end
    end
    if (legal && we) begin
      ref_arr[int'(a / 8)] = wd;
      ref_vld[int'(a / 8)] = 1'b1;
    end
    m_last = port;
    n_txn++;
  endtask

  function automatic logic [63:0] rand_addr();
    int          k;
    logic [63:0] a;
    k = $urandom_range(0, 9);
    case (k)
      0:       a = 64'($urandom_range(0, WORDS - 1)) * 8 + 64'($urandom_range(1, 7));
      1:       a = 64'(MEM_BYTES) + 64'($urandom_range(0, WORDS - 1)) * 8;
      2:       a = 64'(MEM_BYTES - 8);
      default: a = 64'($urandom_range(0, WORDS - 1)) * 8;
    endcase
    return a;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset:ctl", {58'd0, ack0, ack1, err, busy, mem_read, mem_write}, 64'd0);
    check("reset:rdata", rdata, 64'd0);
    check("reset:mem_addr", mem_addr, 64'd0);
    check("reset:mem_data", mem_data, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Preloaded read on port 0.
    next_cycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
    expect_txn("read0");
    next_cycle();
    req0 = 1'b0;

    // Port 1 write, then the held request is renewed as a read of the same word.
    next_cycle();
    req1 = 1'b1; we1 = 1'b1; addr1 = 64'h20; wdata1 = 64'hDEADBEEF00C0FFEE;
    expect_txn("write1");
    next_cycle();
    we1 = 1'b0;
    expect_txn("readback1");
    check("readback1:value", rdata, 64'hDEADBEEF00C0FFEE);
    next_cycle();
    req1 = 1'b0;

    // Contention: both held for four accesses.
    next_cycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'h20;
    for (int i = 0; i < 4; i++) begin
      expect_txn($sformatf("contend%0d", i));
      check($sformatf("contend%0d:order", i), 64'(obs_port), 64'(i % 2));
      next_cycle();
    end
    req0 = 1'b0; req1 = 1'b0;

    // Illegal and boundary addresses on port 1.
    next_cycle();
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'h13;
    expect_txn("illegal_13");
    next_cycle();
    addr1 = 64'h3FC;
    expect_txn("illegal_3fc");
    next_cycle();
    addr1 = 64'h400;
    expect_txn("illegal_400");
    next_cycle();
    addr1 = 64'h3F8;
    expect_txn("boundary_3f8");
    next_cycle();
    req1 = 1'b0;

    // Timeout, then a normal access.
    next_cycle();
    withhold = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
    expect_txn("timeout");
    next_cycle();
    withhold = 1'b0;
    expect_txn("after_timeout");
    next_cycle();
    req0 = 1'b0;

    // Randomized traffic; a losing requester keeps its request and fields unchanged.
    next_cycle();
    req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = rand_addr(); wdata0 = {$urandom, $urandom};
    req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1)); addr1 = rand_addr();
    wdata1 = {$urandom, $urandom};
    for (int n = 0; n < 24; n++) begin
      expect_txn($sformatf("rand%0d", n));
      next_cycle();
      if (obs_port == 1'b0) begin
        req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
        addr0 = rand_addr(); wdata0 = {$urandom, $urandom};
      end else begin
        req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
        addr1 = rand_addr(); wdata1 = {$urandom, $urandom};
      end
      if (!req0 && !req1) begin
        if (obs_port == 1'b0) req0 = 1'b1;
        else req1 = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset while waiting on memory: no ack, outputs cleared, port 0 wins afterwards.
    repeat (3) next_cycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
    repeat (5) next_cycle();
    @(negedge clk);
    check("rst_mid:busy_before", 64'(busy), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    check("rst_mid:ctl", {58'd0, ack0, ack1, err, busy, mem_read, mem_write}, 64'd0);
    check("rst_mid:rdata", rdata, 64'd0);
    check("rst_mid:mem_addr", mem_addr, 64'd0);
    check("rst_mid:mem_data", mem_data, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_last = 1'b1;
    repeat (12) next_cycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'h20;
    expect_txn("post_reset");
    check("post_reset:winner", 64'(obs_port), 64'd0);
    next_cycle();
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) next_cycle();
    check("total_acks", 64'(ack_cnt), 64'(n_txn));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
